// File: rtl/qarma_stream_pkg.sv
// Shared types and constants for the QARMA stream wrapper.
package qarma_stream_pkg;

   localparam int unsigned WORD_W            = 32;
   localparam int unsigned BLK_W             = 128;
   localparam int unsigned IDX_W             = 5;
   localparam int unsigned WAIT_W            = 4;
   localparam int unsigned FRAME_WORDS       = 20;
   localparam int unsigned SHORT_FRAME_WORDS = 12;
   localparam int unsigned KEY_WORDS         = 8;

   localparam int unsigned K0_BASE = 0;
   localparam int unsigned K1_BASE = 4;
   localparam int unsigned T0_BASE = 8;
   localparam int unsigned T1_BASE = 12;
   localparam int unsigned P_BASE  = 16;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_e;

   typedef struct packed {
      logic [BLK_W-1:0] k0;
      logic [BLK_W-1:0] k1;
      logic [BLK_W-1:0] t0;
      logic [BLK_W-1:0] t1;
      logic [BLK_W-1:0] p;
   } qarma_ops_t;

   // Word idx of a 128-bit block, word 0 being the most significant.
   function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                  input logic [1:0]       idx);
      return blk[{~idx, 5'b0} +: WORD_W];
   endfunction

endpackage

// File: rtl/qarma_word_deser.sv
// Writes one 32-bit stream word into the K0/K1/T0/T1/P operand registers by frame word index.
module qarma_word_deser
   import qarma_stream_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   output qarma_ops_t        ops
);

   qarma_ops_t ops_q;
   qarma_ops_t ops_d;
   logic [1:0] lane;

   // Word 0 of each operand lands in bits [127:96].
   always_comb begin
      ops_d = ops_q;
      lane  = ~wr_idx[1:0];
      if (wr_en && (wr_idx < IDX_W'(FRAME_WORDS))) begin
         if (wr_idx >= IDX_W'(P_BASE)) begin
            ops_d.p[{lane, 5'b0} +: WORD_W] = wr_data;
         end else if (wr_idx >= IDX_W'(T1_BASE)) begin
            ops_d.t1[{lane, 5'b0} +: WORD_W] = wr_data;
         end else if (wr_idx >= IDX_W'(T0_BASE)) begin
            ops_d.t0[{lane, 5'b0} +: WORD_W] = wr_data;
         end else if (wr_idx >= IDX_W'(K1_BASE)) begin
            ops_d.k1[{lane, 5'b0} +: WORD_W] = wr_data;
         end else begin
            ops_d.k0[{lane, 5'b0} +: WORD_W] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_q <= '0;
      end else begin
         ops_q <= ops_d;
      end
   end

   assign ops = ops_q;

endmodule

// File: rtl/qarma_stream_if.sv
// Stream front-end for a combinational QARMA core: deserialises operand frames, waits
// CORE_WAIT cycles for the core, then streams the 128-bit result. Option: QARMA_KEY_REUSE_EN.
module qarma_stream_if
   import qarma_stream_pkg::*;
#(
   parameter int unsigned CORE_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_enc,
   input  logic              s_keep_key,
   output logic              core_enc,
   output logic [BLK_W-1:0]  core_K0,
   output logic [BLK_W-1:0]  core_K1,
   output logic [BLK_W-1:0]  core_T0,
   output logic [BLK_W-1:0]  core_T1,
   output logic [BLK_W-1:0]  core_P,
   input  logic [BLK_W-1:0]  core_C,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last
);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    word_cnt_q, word_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [1:0]          out_cnt_q, out_cnt_d;
   logic [BLK_W-1:0]    result_q, result_d;
   logic                enc_q, enc_d;
   logic                s_ready_q, s_ready_d;
   logic                m_valid_q, m_valid_d;
   logic [WORD_W-1:0]   m_data_q, m_data_d;
   logic                m_last_q, m_last_d;
   logic                s_acc_c;
   logic                m_acc_c;
   logic [IDX_W-1:0]    wr_idx_c;
   qarma_ops_t          ops;

`ifndef QARMA_KEY_REUSE_EN
   logic unused_keep;
   assign unused_keep = s_keep_key;
`endif

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      wait_cnt_d = wait_cnt_q;
      out_cnt_d  = out_cnt_q;
      result_d   = result_q;
      enc_d      = enc_q;
      s_acc_c    = s_valid && s_ready_q;
      m_acc_c    = m_valid_q && m_ready;
      wr_idx_c   = word_cnt_q;
`ifdef QARMA_KEY_REUSE_EN
      // A key-reuse frame skips K0/K1 and starts writing at T0.
      if ((word_cnt_q == '0) && s_keep_key) begin
         wr_idx_c = IDX_W'(KEY_WORDS);
      end
`endif

      case (state_q)
         LOAD: begin
            if (s_acc_c) begin
               if (word_cnt_q == '0) begin
                  enc_d = s_enc;
               end
               if (wr_idx_c == IDX_W'(FRAME_WORDS - 1)) begin
                  word_cnt_d = '0;
                  wait_cnt_d = '0;
                  state_d    = WAIT;
               end else begin
                  word_cnt_d = wr_idx_c + 5'd1;
               end
            end
         end
         WAIT: begin
            if (wait_cnt_q == WAIT_W'(CORE_WAIT)) begin
               result_d   = core_C;
               wait_cnt_d = '0;
               out_cnt_d  = '0;
               state_d    = SEND;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         SEND: begin
            if (m_acc_c) begin
               out_cnt_d = out_cnt_q + 2'd1;
               if (out_cnt_q == 2'd3) begin
                  state_d = LOAD;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase

      // Outputs are registered copies of what the next state will present.
      s_ready_d = (state_d == LOAD);
      m_valid_d = (state_d == SEND);
      m_last_d  = (state_d == SEND) && (out_cnt_d == 2'd3);
      m_data_d  = (state_d == SEND) ? blk_word(result_d, out_cnt_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LOAD;
         word_cnt_q <= '0;
         wait_cnt_q <= '0;
         out_cnt_q  <= '0;
         result_q   <= '0;
         enc_q      <= 1'b0;
         s_ready_q  <= 1'b1;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         out_cnt_q  <= out_cnt_d;
         result_q   <= result_d;
         enc_q      <= enc_d;
         s_ready_q  <= s_ready_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_last_q   <= m_last_d;
      end
   end

   qarma_word_deser u_deser (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (s_acc_c),
      .wr_idx  (wr_idx_c),
      .wr_data (s_data),
      .ops     (ops)
   );

   assign s_ready  = s_ready_q;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_last   = m_last_q;
   assign core_enc = enc_q;
   assign core_K0  = ops.k0;
   assign core_K1  = ops.k1;
   assign core_T0  = ops.t0;
   assign core_T1  = ops.t1;
   assign core_P   = ops.p;

endmodule

// File: tb/tb_qarma_stream_if.sv
// Directed bench for qarma_stream_if; instance 0 uses CORE_WAIT=2, instances 1/2 use 1/15.
module tb_qarma_stream_if;

   localparam int unsigned NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_enc;
   logic        s_keep_key;
   logic        m_ready;

   logic         sr [NI];
   logic         mv [NI];
   logic         ml [NI];
   logic         ce [NI];
   logic [31:0]  md [NI];
   logic [127:0] k0 [NI];
   logic [127:0] k1 [NI];
   logic [127:0] t0 [NI];
   logic [127:0] t1 [NI];
   logic [127:0] pp [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned CW = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic [127:0] c_stub;
      assign c_stub = pp[g] ^ k0[g];
      qarma_stream_if #(.CORE_WAIT(CW)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .s_valid    (s_valid),
         .s_ready    (sr[g]),
         .s_data     (s_data),
         .s_enc      (s_enc),
         .s_keep_key (s_keep_key),
         .core_enc   (ce[g]),
         .core_K0    (k0[g]),
         .core_K1    (k1[g]),
         .core_T0    (t0[g]),
         .core_T1    (t1[g]),
         .core_P     (pp[g]),
         .core_C     (c_stub),
         .m_valid    (mv[g]),
         .m_ready    (m_ready),
         .m_data     (md[g]),
         .m_last     (ml[g])
      );
   end

   typedef struct {
      logic [31:0]  base;
      logic [31:0]  step;
      logic         keep;
      logic         enc;
      int           nwords;
      logic [127:0] k0;
      logic [127:0] k1;
      logic [127:0] t0;
      logic [127:0] p;
      logic [127:0] c;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the last accept (or when s_ready drops).
   task automatic send_frame(input logic [31:0] base, input logic [31:0] step, input logic keep,
                             input logic enc, input int maxw, output int cnt);
      cnt = 0;
      for (int i = 0; i < maxw; i++) begin
         if (!sr[0]) break;
         s_valid    = 1'b1;
         s_data     = base + 32'(i) * step;
         s_enc      = enc;
         s_keep_key = (i == 0) ? keep : 1'b0;
         @(posedge clk);
         @(negedge clk);
         s_valid    = 1'b0;
         s_keep_key = 1'b0;
         cnt++;
      end
   endtask

   task automatic recv_frame(input logic [127:0] c, input int stall_word, input int stall_cyc,
                             output int lat);
      lat = -1;
      for (int w = 0; w < 4; w++) begin
         int n = 0;
         logic [31:0] ew;
         ew = c[(3 - w) * 32 +: 32];
         while (!mv[0] && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (w == 0) lat = n;
         if (!mv[0]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL m_valid_timeout: word %0d never became valid", w);
            return;
         end
         if (w == stall_word) begin
            m_ready = 1'b0;
            for (int s = 0; s < stall_cyc; s++) begin
               @(negedge clk);
               chk("stall_m_valid", 128'(mv[0]), 128'd1);
               chk("stall_m_data", 128'(md[0]), 128'(ew));
            end
            m_ready = 1'b1;
         end
         chk("m_data", 128'(md[0]), 128'(ew));
         chk("m_last", 128'(ml[0]), 128'(w == 3));
         @(negedge clk);
      end
      chk("m_valid_after_frame", 128'(mv[0]), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[3];
      int   cnt;
      int   lat;
      int   lats[NI];
      int   k;
      int   tp1;
      int   tp2;

      vecs[0] = '{base: 32'h1, step: 32'h1, keep: 1'b0, enc: 1'b1, nwords: 20,
                  k0: 128'h00000001_00000002_00000003_00000004,
                  k1: 128'h00000005_00000006_00000007_00000008,
                  t0: 128'h00000009_0000000A_0000000B_0000000C,
                  p:  128'h00000011_00000012_00000013_00000014,
                  c:  128'h00000010_00000010_00000010_00000010};
      vecs[1] = '{base: 32'h1000_0000, step: 32'h1111, keep: 1'b0, enc: 1'b0, nwords: 20,
                  k0: 128'h10000000_10001111_10002222_10003333,
                  k1: 128'h10004444_10005555_10006666_10007777,
                  t0: 128'h10008888_10009999_1000AAAA_1000BBBB,
                  p:  128'h10011110_10012221_10013332_10014443,
                  c:  128'h00011110_00013330_00011110_00017770};
`ifdef QARMA_KEY_REUSE_EN
      vecs[2] = '{base: 32'hA000_0000, step: 32'h1, keep: 1'b1, enc: 1'b1, nwords: 12,
                  k0: 128'h10000000_10001111_10002222_10003333,
                  k1: 128'h10004444_10005555_10006666_10007777,
                  t0: 128'hA0000000_A0000001_A0000002_A0000003,
                  p:  128'hA0000008_A0000009_A000000A_A000000B,
                  c:  128'hB0000008_B0001118_B0002228_B0003338};
`else
      vecs[2] = '{base: 32'hA000_0000, step: 32'h1, keep: 1'b1, enc: 1'b1, nwords: 20,
                  k0: 128'hA0000000_A0000001_A0000002_A0000003,
                  k1: 128'hA0000004_A0000005_A0000006_A0000007,
                  t0: 128'hA0000008_A0000009_A000000A_A000000B,
                  p:  128'hA0000010_A0000011_A0000012_A0000013,
                  c:  128'h00000010_00000010_00000010_00000010};
`endif

      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_enc      = 1'b0;
      s_keep_key = 1'b0;
      m_ready    = 1'b1;
      idle(3);

      chk("rst_s_ready", 128'(sr[0]), 128'd1);
      chk("rst_m_valid", 128'(mv[0]), 128'd0);
      chk("rst_m_last", 128'(ml[0]), 128'd0);
      chk("rst_m_data", 128'(md[0]), 128'd0);
      chk("rst_core_enc", 128'(ce[0]), 128'd0);
      chk("rst_core_k0", k0[0], 128'd0);
      chk("rst_core_p", pp[0], 128'd0);
      rst_n = 1'b1;
      idle(2);
      chk("post_rst_s_ready", 128'(sr[0]), 128'd1);

      // Table-driven frames; the third relies on K0/K1 left by the second.
      for (int v = 0; v < 3; v++) begin
         send_frame(vecs[v].base, vecs[v].step, vecs[v].keep, vecs[v].enc, 20, cnt);
         chk("frame_words", 128'(cnt), 128'(vecs[v].nwords));
         chk("s_ready_after_frame", 128'(sr[0]), 128'd0);
         chk("core_k0", k0[0], vecs[v].k0);
         chk("core_k1", k1[0], vecs[v].k1);
         chk("core_t0", t0[0], vecs[v].t0);
         chk("core_p", pp[0], vecs[v].p);
         chk("core_enc", 128'(ce[0]), 128'(vecs[v].enc));
         recv_frame(vecs[v].c, -1, 0, lat);
         chk("latency_cw2", 128'(lat), 128'd3);
         chk("core_p_stable", pp[0], vecs[v].p);
         chk("core_k0_stable", k0[0], vecs[v].k0);
         idle(20);
      end

      // Back-pressure: hold m_ready low for 5 cycles while word 1 is presented.
      send_frame(32'h1, 32'h1, 1'b0, 1'b1, 20, cnt);
      chk("stall_frame_words", 128'(cnt), 128'd20);
      recv_frame(vecs[0].c, 1, 5, lat);
      idle(20);

      // Reset after 7 words, then a fresh full frame.
      send_frame(32'h1000_0000, 32'h1111, 1'b0, 1'b1, 7, cnt);
      chk("partial_words", 128'(cnt), 128'd7);
      rst_n = 1'b0;
      #1;
      chk("midrst_core_k0", k0[0], 128'd0);
      chk("midrst_core_k1", k1[0], 128'd0);
      chk("midrst_core_t0", t0[0], 128'd0);
      chk("midrst_core_t1", t1[0], 128'd0);
      chk("midrst_core_p", pp[0], 128'd0);
      chk("midrst_core_enc", 128'(ce[0]), 128'd0);
      chk("midrst_s_ready", 128'(sr[0]), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(32'h1, 32'h1, 1'b0, 1'b1, 20, cnt);
      chk("after_rst_words", 128'(cnt), 128'd20);
      chk("after_rst_core_k0", k0[0], vecs[0].k0);
      chk("after_rst_core_k1", k1[0], vecs[0].k1);
      chk("after_rst_core_p", pp[0], vecs[0].p);
      recv_frame(vecs[0].c, -1, 0, lat);
      idle(20);

      // First m_valid after last accept for CORE_WAIT = 2, 1, 15.
      send_frame(32'h1, 32'h1, 1'b0, 1'b1, 20, cnt);
      for (int g = 0; g < NI; g++) lats[g] = -1;
      for (int i = 0; i <= 20; i++) begin
         for (int g = 0; g < NI; g++) begin
            if (lats[g] < 0 && mv[g]) lats[g] = i;
         end
         @(negedge clk);
      end
      chk("latency_cw2_inst", 128'(lats[0]), 128'd3);
      chk("latency_cw1", 128'(lats[1]), 128'd2);
      chk("latency_cw15", 128'(lats[2]), 128'd16);
      idle(5);

      // Continuous input with m_ready high: spacing between frame starts.
      k   = 0;
      tp1 = -1;
      tp2 = -1;
      for (int c = 0; c < 100 && k < 40; c++) begin
         s_valid    = 1'b1;
         s_data     = 32'(k % 20) + 32'd1;
         s_enc      = 1'b1;
         s_keep_key = 1'b0;
         if (sr[0]) begin
            if (k == 0) tp1 = c;
            if (k == 20) tp2 = c;
            k++;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("throughput_cycles", 128'(tp2 - tp1), 128'd27);
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/qarma_stream_if.md
QARMA_STREAM_IF -- requirements
Module: qarma_stream_if

Interface
REQ-001 SHALL have parameter CORE_WAIT, default 2, meaning cycles (range 1..15) between operand freeze and sampling of core_C.
REQ-002 SHALL have one clock and one reset: clk input 1 (rising-edge clock); rst_n input 1 (reset, asynchronous, active-low).
REQ-003 s_valid input 1: inbound word valid.
REQ-004 s_ready output 1: inbound word accepted when s_valid and s_ready are both high.
REQ-005 s_data input 32: inbound word.
REQ-006 s_enc input 1: direction (1 = encrypt), sampled with frame word 0.
REQ-007 s_keep_key input 1: key-reuse request, sampled with frame word 0.
REQ-008 core_enc output 1, core_K0/core_K1/core_T0/core_T1/core_P output 128 each: operands to the combinational cipher core.
REQ-009 core_C input 128: result from the cipher core.
REQ-010 m_valid output 1, m_ready input 1, m_data output 32, m_last output 1: outbound result stream.

Function
REQ-011 SHALL implement FSM states LOAD, WAIT, SEND.
REQ-012 Full frame is 20 words in this order: K0, K1, T0, T1, P. Each operand is 4 words, most-significant word first, so word 0 goes to bits [127:96].
REQ-013 LOAD: s_ready=1; each accepted word is written into the operand register addressed by a 5-bit word counter. The counter increments per accept.
REQ-014 LOAD to WAIT: on acceptance of the frame's final word. Word counter clears to 0.
REQ-015 WAIT: s_ready=0; a wait counter runs 1..CORE_WAIT. When it reaches CORE_WAIT, core_C is registered into a 128-bit result register and the FSM moves to SEND.
REQ-016 SEND: m_valid=1; m_data = result word selected by a 2-bit counter, [127:96] first; m_last=1 on word 3 only.
REQ-017 SEND: the counter advances only on m_valid and m_ready. After word 3 is accepted, the FSM moves to LOAD on the next cycle.
REQ-018 While m_ready=0, m_data and m_last SHALL hold stable.
REQ-019 core_* outputs change only on accepted LOAD words and stay constant throughout WAIT and SEND (multicycle-path guarantee).
REQ-020 Latency: the first m_valid occurs CORE_WAIT+1 cycles after the final input word is accepted.
REQ-021 Throughput: with a 20-word frame, m_ready held high and CORE_WAIT=2, one frame completes every 27 cycles.
REQ-022 s_valid while s_ready=0 SHALL be ignored, with no state change.

Reset
REQ-023 rst_n low SHALL, asynchronously: put the FSM in LOAD; clear all counters; clear all operand and result registers to 0; set core_enc=0.
REQ-024 Reset outputs SHALL be: s_ready=1, m_valid=0, m_last=0, m_data=0.
REQ-025 Reset mid-frame SHALL discard partial input or pending output. The next accepted word is treated as frame word 0.

Configuration
REQ-026 With QARMA_KEY_REUSE_EN defined: if s_keep_key=1 on word 0, the frame is 12 words (T0, T1, P). K0 and K1 retain their previous values and the counter starts at word index 8.
REQ-027 Without QARMA_KEY_REUSE_EN: s_keep_key is ignored (port kept) and every frame is 20 words.

Structure
REQ-028 A shared package qarma_stream_pkg SHALL hold: the state enum (LOAD/WAIT/SEND); constants FRAME_WORDS=20, SHORT_FRAME_WORDS=12, KEY_WORDS=8; and the operand base indices (K0=0, K1=4, T0=8, T1=12, P=16).
REQ-029 One sub-module, qarma_word_deser, SHALL write a 32-bit word into five 128-bit operand registers by word index. The cipher core is instantiated outside this block.

Verification
REQ-030 Bench drives words 0x00000001..0x00000014, s_enc=1, with a core stub C = P ^ K0. Required: core_K0 = 0x00000001_00000002_00000003_00000004 and core_P = 0x00000011_00000012_00000013_00000014. Outputs are 0x00000010, 0x00000010, 0x00000010, 0x00000010, with m_last on the 4th.
REQ-031 Same frame with m_ready held low 5 cycles on word 1. Required: m_data stays 0x00000010 and m_valid stays 1 for those cycles, with no word loss or duplication.
REQ-032 Assert rst_n low after 7 input words, then send a full frame. Required: the output matches a fresh 20-word frame, and all core_* were 0 immediately after reset.
REQ-033 With QARMA_KEY_REUSE_EN, a second frame has s_keep_key=1 and 12 words 0xA0000000+i. Required: core_K0/core_K1 unchanged from the prior frame, and core_T0 = 0xA0000000_..01_..02_..03.
REQ-034 Without the macro, the same s_keep_key=1 stimulus requires 20 words before s_ready drops.
REQ-035 For CORE_WAIT=1 and CORE_WAIT=15, the first m_valid SHALL come 2 and 16 cycles respectively after the last input accept.
